// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch PC owner with in-order request/grant fetch and decode FIFO
// Redirects from execute discard buffered entries and drop in-flight responses by count.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ex_valid,
   input  logic        i_pc_sel,
   input  logic [31:0] i_alu_data,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_valid,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   input  logic        i_id_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } state_e;

   state_e         state_q;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [31:0]    resp_pc_q, resp_pc_d;
   logic [CW-1:0]  out_cnt_q, out_cnt_d;
   logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]    instr_mem_q [DEPTH];
   logic [31:0]    pc_mem_q [DEPTH];

   logic           redir;
   logic           grant;
   logic           resp;
   logic           drop;
   logic           push;
   logic           pop;
   logic           credit_ok;
   logic [31:0]    target;
   logic [CW-1:0]  live_out;
   logic [CW:0]    credit_sum;

   assign redir      = i_ex_valid & i_pc_sel;
   assign target     = {i_alu_data[31:2], 2'b00};
   // Credit counts buffered plus in-flight words, so every response is guaranteed a FIFO slot.
   assign credit_sum = {1'b0, out_cnt_q} + {1'b0, cnt_q};
   assign credit_ok  = credit_sum < DEPTH_C;

   assign o_imem_req  = (state_q != BOOT) & ~redir & credit_ok;
   assign o_imem_addr = fetch_pc_q;
   assign grant       = o_imem_req & i_imem_gnt;

   assign resp     = i_imem_rvalid & (out_cnt_q != '0);
   assign drop     = resp & (drop_cnt_q != '0);
   assign push     = resp & ~drop & ~redir;
   assign pop      = o_if_valid & i_id_ready & ~redir;
   assign live_out = out_cnt_q - CW'(resp);

   assign o_if_valid = (cnt_q != '0);
   assign o_if_instr = instr_mem_q[rd_ptr_q];
   assign o_if_pc    = pc_mem_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
      out_cnt_d  = out_cnt_q + CW'(grant) - CW'(resp);
      drop_cnt_d = drop_cnt_q - CW'(drop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      // A response landing in the redirect cycle is already stale and is not counted again.
      if (redir) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         drop_cnt_d = live_out;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= RESET_PC;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push) begin
            instr_mem_q[wr_ptr_q] <= i_imem_rdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         end
         case (state_q)
            BOOT:    state_q <= RUN;
            RUN:     if (redir && live_out != '0) state_q <= FLUSH;
            FLUSH:   if (!redir && drop_cnt_d == '0) state_q <= RUN;
            default: state_q <= BOOT;
         endcase
      end
   end

endmodule
